stream_mux: RTL and testbench
=============================

# stream_mux

Parametrised N:1 streaming multiplexer with a valid/ready handshake on every port, packet locking and a registered output stage. It generalises the team's combinational 2:1 select mux into a channel-count- and width-parametrised block. It sits between several packet producers and a single downstream consumer. Selection is either an external select port or internal round-robin arbitration, chosen at elaboration time.

## Interface
Parameters:
- WIDTH, 8: data bits per beat.
- CHANNELS, 4: number of input channels; must be at least 2.
- RR_MODE, 0: 0 selects by the `sel` port; 1 selects by round-robin arbitration, and `sel` is ignored.
- SEL_W, derived: clog2(CHANNELS); local, not overridable.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- din_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- din_valid  in  CHANNELS  per-channel beat valid.
- din_last  in  CHANNELS  per-channel end-of-packet flag, qualified by din_valid.
- din_ready  out  CHANNELS  per-channel accept; combinational.
- sel  in  SEL_W  channel select; used only when RR_MODE=0.
- mux_out  out  WIDTH  registered output data.
- mux_valid  out  1  output beat valid.
- mux_last  out  1  output end-of-packet flag.
- mux_chan  out  SEL_W  source channel index of the current output beat.
- mux_ready  in  1  downstream accept.

## Operation
- One clock domain: clk. Reset is asynchronous and active-low: reset_n.
- load_en = !mux_valid | mux_ready. The output register may take a new beat when load_en is high.
- A transfer on an input occurs when din_valid[i] & din_ready[i] are both high.
- A transfer on the output occurs when mux_valid & mux_ready are both high.
- State machine with two states: IDLE and LOCKED. A register `gnt` (SEL_W bits) holds the locked channel.
- Candidate channel in IDLE:
  - RR_MODE=0: cand = sel. If sel >= CHANNELS, there is no candidate.
  - RR_MODE=1: cand = the first channel with din_valid set, searching cyclically from ptr+1. If no channel is valid, there is no candidate.
- Candidate channel in LOCKED: cand = gnt. In RR_MODE=0, `sel` is ignored while LOCKED.
- din_ready[cand] = load_en. All other din_ready bits are 0. If there is no candidate, all din_ready bits are 0.
- On an input transfer from channel c:
  - mux_out <= din_data[c]; mux_last <= din_last[c]; mux_chan <= c; mux_valid <= 1.
- State transitions:
  - IDLE, transfer with last=0 -> LOCKED, gnt <= c.
  - IDLE, transfer with last=1 -> stays IDLE (single-beat packet).
  - LOCKED, transfer with last=1 -> IDLE.
  - Any other case: hold state.
- Round-robin pointer: ptr <= c on the final beat of each packet. RR_MODE=1 only.
- With no input transfer and an output transfer, mux_valid <= 0. mux_out, mux_last and mux_chan hold their last values.
- Backpressure: while mux_valid & !mux_ready, all output registers are held stable.
- Packets from different channels are never interleaved on the output.

## Timing
- Reset values, applied immediately on reset_n low, independent of clk:
  - mux_valid=0, mux_out=0, mux_last=0, mux_chan=0.
  - state=IDLE, gnt=0, ptr=CHANNELS-1, so the first round-robin search starts at channel 0.
- During reset, din_ready is all 0.
- Latency: a beat accepted at edge n is visible on mux_out after edge n.
- Throughput: one beat per cycle when mux_ready is held high.
- Simultaneous output drain and input accept in the same cycle: the new beat replaces the old one and mux_valid stays 1, with no bubble.
- If reset is asserted mid-packet, the block returns to IDLE. The partial packet is abandoned and no last beat is emitted.
- din_ready may depend combinationally on mux_ready, din_valid and sel. There is no combinational path from any input to mux_out, mux_valid, mux_last or mux_chan.

## Test plan
- RR_MODE=0, sel=2, a 3-beat packet on channel 2 (0x11, 0x22, 0x33 with last on the third beat), mux_ready=1 -> mux_out shows 0x11, 0x22, 0x33 on consecutive cycles, each one edge after acceptance; mux_chan=2; mux_last high only with 0x33.
- RR_MODE=0, sel changed from 2 to 0 after the first beat of a 3-beat packet on channel 2 -> remaining beats still come from channel 2; channel 0's first beat is accepted only in the cycle after the last beat.
- RR_MODE=1, all 4 channels continuously valid with single-beat packets -> grant order is 0, 1, 2, 3, 0, 1 at one beat per cycle.
- mux_ready held low for 3 cycles with a beat pending -> mux_out, mux_last and mux_chan stay stable; din_ready is all 0; no beat is lost or duplicated when mux_ready returns high.
- reset_n pulsed low in the middle of a LOCKED packet on channel 1 while channel 3 is valid (RR_MODE=1) -> outputs take their reset values immediately; after release, channel 3 is granted without waiting for channel 1's last beat.
- RR_MODE=0 with CHANNELS=3, sel=3 (out of range) -> din_ready stays 0 and mux_valid stays 0.

Source files
------------

// File: rtl/stream_mux.sv
// N:1 valid/ready stream multiplexer with packet locking and a registered output stage.
// The channel comes from the sel port or from a round-robin search, chosen by RR_MODE.
module stream_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int RR_MODE  = 0,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] din_data,
    input  logic [CHANNELS-1:0]       din_valid,
    input  logic [CHANNELS-1:0]       din_last,
    output logic [CHANNELS-1:0]       din_ready,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          mux_out,
    output logic                      mux_valid,
    output logic                      mux_last,
    output logic [SEL_W-1:0]          mux_chan,
    input  logic                      mux_ready
);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   gnt_q, gnt_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0]   mux_out_q, mux_out_d;
    logic               mux_valid_q, mux_valid_d;
    logic               mux_last_q, mux_last_d;
    logic [SEL_W-1:0]   mux_chan_q, mux_chan_d;

    logic [SEL_W-1:0]   cand;
    logic               cand_ok;
    logic               cand_valid;
    logic               cand_last;
    logic [WIDTH-1:0]   cand_data;
    logic               load_en;
    logic               xfer;

    assign load_en = !mux_valid_q || mux_ready;

    // A locked packet owns the output until its last beat; otherwise pick a fresh candidate.
    always_comb begin
        cand    = '0;
        cand_ok = 1'b0;
        if (state_q == LOCKED) begin
            cand    = gnt_q;
            cand_ok = 1'b1;
        end else if (RR_MODE == 0) begin
            if (int'(sel) < CHANNELS) begin
                cand    = sel;
                cand_ok = 1'b1;
            end
        end else begin
            // Cyclic search from ptr+1: channels above ptr first, then wrap to 0..ptr.
            for (int i = 0; i < CHANNELS; i++) begin
                if (!cand_ok && din_valid[i] && (SEL_W'(i) > ptr_q)) begin
                    cand    = SEL_W'(i);
                    cand_ok = 1'b1;
                end
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (!cand_ok && din_valid[i] && (SEL_W'(i) <= ptr_q)) begin
                    cand    = SEL_W'(i);
                    cand_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cand_valid = 1'b0;
        cand_last  = 1'b0;
        cand_data  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (SEL_W'(i) == cand) begin
                cand_valid = din_valid[i];
                cand_last  = din_last[i];
                cand_data  = din_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = reset_n && cand_ok && cand_valid && load_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= SEL_W'(CHANNELS - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            if (state_q == IDLE && !cand_last) begin
                state_d = LOCKED;
                gnt_d   = cand;
            end else if (state_q == LOCKED && cand_last) begin
                state_d = IDLE;
            end
            if (cand_last && RR_MODE != 0) ptr_d = cand;
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++)
            din_ready[i] = reset_n && cand_ok && load_en && (SEL_W'(i) == cand);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mux_out_q   <= '0;
            mux_valid_q <= 1'b0;
            mux_last_q  <= 1'b0;
            mux_chan_q  <= '0;
        end else begin
            mux_out_q   <= mux_out_d;
            mux_valid_q <= mux_valid_d;
            mux_last_q  <= mux_last_d;
            mux_chan_q  <= mux_chan_d;
        end
    end

    // A new beat may replace a draining one in the same cycle, so there is no bubble.
    always_comb begin
        mux_out_d   = mux_out_q;
        mux_valid_d = mux_valid_q;
        mux_last_d  = mux_last_q;
        mux_chan_d  = mux_chan_q;
        if (xfer) begin
            mux_out_d   = cand_data;
            mux_last_d  = cand_last;
            mux_chan_d  = cand;
            mux_valid_d = 1'b1;
        end else if (mux_ready) begin
            mux_valid_d = 1'b0;
        end
    end

    assign mux_out   = mux_out_q;
    assign mux_valid = mux_valid_q;
    assign mux_last  = mux_last_q;
    assign mux_chan  = mux_chan_q;

endmodule

// File: tb/tb_stream_mux.sv
// Bench for stream_mux: select-mode, round-robin and 3-channel instances, directed
// scenarios plus a random packet stream checked against per-channel beat queues.
module tb_stream_mux;
    localparam int W = 8;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // select-mode instance
    logic [C*W-1:0] d0_data;
    logic [C-1:0]   d0_valid, d0_last, d0_ready;
    logic [1:0]     sel0, m0_chan;
    logic [W-1:0]   m0_out;
    logic           m0_valid, m0_last, m0_ready;
    // round-robin instance
    logic [C*W-1:0] d1_data;
    logic [C-1:0]   d1_valid, d1_last, d1_ready;
    logic [1:0]     sel1, m1_chan;
    logic [W-1:0]   m1_out;
    logic           m1_valid, m1_last, m1_ready;
    // 3-channel select-mode instance
    logic [3*W-1:0] d2_data;
    logic [2:0]     d2_valid, d2_last, d2_ready;
    logic [1:0]     sel2, m2_chan;
    logic [W-1:0]   m2_out;
    logic           m2_valid, m2_last, m2_ready;

    stream_mux #(.WIDTH(W), .CHANNELS(C), .RR_MODE(0)) u_sel (
        .clk(clk), .reset_n(rst_n), .din_data(d0_data), .din_valid(d0_valid),
        .din_last(d0_last), .din_ready(d0_ready), .sel(sel0), .mux_out(m0_out),
        .mux_valid(m0_valid), .mux_last(m0_last), .mux_chan(m0_chan), .mux_ready(m0_ready));

    stream_mux #(.WIDTH(W), .CHANNELS(C), .RR_MODE(1)) u_rr (
        .clk(clk), .reset_n(rst_n), .din_data(d1_data), .din_valid(d1_valid),
        .din_last(d1_last), .din_ready(d1_ready), .sel(sel1), .mux_out(m1_out),
        .mux_valid(m1_valid), .mux_last(m1_last), .mux_chan(m1_chan), .mux_ready(m1_ready));

    stream_mux #(.WIDTH(W), .CHANNELS(3), .RR_MODE(0)) u_c3 (
        .clk(clk), .reset_n(rst_n), .din_data(d2_data), .din_valid(d2_valid),
        .din_last(d2_last), .din_ready(d2_ready), .sel(sel2), .mux_out(m2_out),
        .mux_valid(m2_valid), .mux_last(m2_last), .mux_chan(m2_chan), .mux_ready(m2_ready));

    task automatic clear_inputs();
        d0_data = '0; d0_valid = '0; d0_last = '0; sel0 = '0; m0_ready = 1'b1;
        d1_data = '0; d1_valid = '0; d1_last = '0; sel1 = '0; m1_ready = 1'b1;
        d2_data = '0; d2_valid = '0; d2_last = '0; sel2 = '0; m2_ready = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        d0_valid = '1; sel0 = 2'd2; d1_valid = '1; d2_valid = '1;
        #3;
        for (int k = 0; k < 2; k++) begin
            nchk++; if ({m0_valid, m0_out, m0_last, m0_chan} !== '0) begin
                nerr++; $display("FAIL reset_out0 got v=%b d=%h l=%b c=%0d exp all 0", m0_valid, m0_out, m0_last, m0_chan); end
            nchk++; if (m1_valid !== 1'b0 || m1_chan !== 2'd0) begin
                nerr++; $display("FAIL reset_out1 got v=%b c=%0d exp 0 0", m1_valid, m1_chan); end
            nchk++; if (d0_ready !== 4'b0 || d1_ready !== 4'b0 || d2_ready !== 3'b0) begin
                nerr++; $display("FAIL reset_ready got %b %b %b exp 0", d0_ready, d1_ready, d2_ready); end
            @(posedge clk); #1;
        end
        clear_inputs();
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_sel_packet();
        logic [7:0] b [3];
        b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            sel0 = 2'd2; d0_valid = 4'b0100; d0_data[2*W +: W] = b[k];
            d0_last = (k == 2) ? 4'b0100 : 4'b0000; m0_ready = 1'b1;
            #1;
            nchk++; if (d0_ready !== 4'b0100) begin
                nerr++; $display("FAIL sel_pkt_ready beat%0d got %b exp 0100", k, d0_ready); end
            @(posedge clk); #1;
            nchk++; if (m0_valid !== 1'b1 || m0_out !== b[k] || m0_chan !== 2'd2 || m0_last !== (k == 2)) begin
                nerr++; $display("FAIL sel_pkt_out beat%0d got v=%b d=%h c=%0d l=%b exp v=1 d=%h c=2 l=%b",
                                 k, m0_valid, m0_out, m0_chan, m0_last, b[k], k == 2); end
        end
        @(negedge clk); d0_valid = '0; d0_last = '0;
        @(posedge clk); #1;
        nchk++; if (m0_valid !== 1'b0 || m0_out !== 8'h33) begin
            nerr++; $display("FAIL sel_pkt_drain got v=%b d=%h exp v=0 d=33", m0_valid, m0_out); end
    endtask

    task automatic test_sel_lock();
        logic [7:0] b [3];
        b[0] = 8'hA1; b[1] = 8'hA2; b[2] = 8'hA3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            sel0 = (k == 0) ? 2'd2 : 2'd0;
            d0_valid = 4'b0101; d0_data[2*W +: W] = b[k]; d0_data[0 +: W] = 8'hB0;
            d0_last = 4'b0001 | ((k == 2) ? 4'b0100 : 4'b0000);
            #1;
            nchk++; if (d0_ready !== 4'b0100) begin
                nerr++; $display("FAIL lock_ready beat%0d got %b exp 0100", k, d0_ready); end
            @(posedge clk); #1;
            nchk++; if (m0_out !== b[k] || m0_chan !== 2'd2) begin
                nerr++; $display("FAIL lock_out beat%0d got d=%h c=%0d exp d=%h c=2", k, m0_out, m0_chan, b[k]); end
        end
        @(negedge clk); d0_valid = 4'b0001; d0_last = 4'b0001;
        #1;
        nchk++; if (d0_ready !== 4'b0001) begin
            nerr++; $display("FAIL lock_next_ready got %b exp 0001", d0_ready); end
        @(posedge clk); #1;
        nchk++; if (m0_valid !== 1'b1 || m0_out !== 8'hB0 || m0_chan !== 2'd0 || m0_last !== 1'b1) begin
            nerr++; $display("FAIL lock_next_out got v=%b d=%h c=%0d l=%b exp 1 B0 0 1", m0_valid, m0_out, m0_chan, m0_last); end
        @(negedge clk); d0_valid = '0; d0_last = '0;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        sel0 = 2'd1; d0_valid = 4'b0010; d0_data[W +: W] = 8'h5A; d0_last = 4'b0010; m0_ready = 1'b0;
        #1;
        nchk++; if (d0_ready !== 4'b0010) begin
            nerr++; $display("FAIL bp_first_ready got %b exp 0010", d0_ready); end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); d0_data[W +: W] = 8'h6B; m0_ready = 1'b0;
            #1;
            nchk++; if (d0_ready !== 4'b0000) begin
                nerr++; $display("FAIL bp_ready cyc%0d got %b exp 0000", k, d0_ready); end
            @(posedge clk); #1;
            nchk++; if (m0_valid !== 1'b1 || m0_out !== 8'h5A || m0_last !== 1'b1 || m0_chan !== 2'd1) begin
                nerr++; $display("FAIL bp_hold cyc%0d got v=%b d=%h l=%b c=%0d exp 1 5A 1 1", k, m0_valid, m0_out, m0_last, m0_chan); end
        end
        @(negedge clk); m0_ready = 1'b1;
        #1;
        nchk++; if (d0_ready !== 4'b0010) begin
            nerr++; $display("FAIL bp_release_ready got %b exp 0010", d0_ready); end
        @(posedge clk); #1;
        nchk++; if (m0_valid !== 1'b1 || m0_out !== 8'h6B || m0_chan !== 2'd1) begin
            nerr++; $display("FAIL bp_release_out got v=%b d=%h c=%0d exp 1 6B 1", m0_valid, m0_out, m0_chan); end
        @(negedge clk); d0_valid = '0; d0_last = '0;
        @(posedge clk); #1;
        nchk++; if (m0_valid !== 1'b0) begin
            nerr++; $display("FAIL bp_no_dup got v=%b exp 0", m0_valid); end
    endtask

    task automatic test_rr_order();
        int ord [6];
        ord[0] = 0; ord[1] = 1; ord[2] = 2; ord[3] = 3; ord[4] = 0; ord[5] = 1;
        @(negedge clk);
        d1_valid = '1; d1_last = '1; m1_ready = 1'b1;
        for (int i = 0; i < C; i++) d1_data[i*W +: W] = 8'(8'h40 + i);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            nchk++; if (d1_ready !== (4'b0001 << ord[k])) begin
                nerr++; $display("FAIL rr_ready step%0d got %b exp chan %0d", k, d1_ready, ord[k]); end
            @(posedge clk); #1;
            nchk++; if (m1_valid !== 1'b1 || int'(m1_chan) != ord[k] || m1_out !== 8'(8'h40 + ord[k])) begin
                nerr++; $display("FAIL rr_out step%0d got v=%b c=%0d d=%h exp chan %0d", k, m1_valid, m1_chan, m1_out, ord[k]); end
        end
        @(negedge clk); d1_valid = '0; d1_last = '0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        d1_valid = 4'b0010; d1_data[W +: W] = 8'h71; d1_last = '0;
        #1;
        nchk++; if (d1_ready !== 4'b0010) begin
            nerr++; $display("FAIL rmid_first got %b exp 0010", d1_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        d1_valid = 4'b1010; d1_data[W +: W] = 8'h72; d1_data[3*W +: W] = 8'h93; d1_last = 4'b1000;
        #1;
        nchk++; if (d1_ready !== 4'b0010) begin
            nerr++; $display("FAIL rmid_locked got %b exp 0010", d1_ready); end
        @(posedge clk); #1;
        nchk++; if (m1_out !== 8'h72 || m1_chan !== 2'd1 || m1_last !== 1'b0) begin
            nerr++; $display("FAIL rmid_beat2 got d=%h c=%0d l=%b exp 72 1 0", m1_out, m1_chan, m1_last); end
        @(negedge clk); rst_n = 1'b0; d1_valid = 4'b1000;
        #1;
        nchk++; if ({m1_valid, m1_out, m1_last, m1_chan} !== '0 || d1_ready !== 4'b0) begin
            nerr++; $display("FAIL rmid_reset got v=%b d=%h l=%b c=%0d r=%b exp all 0", m1_valid, m1_out, m1_last, m1_chan, d1_ready); end
        @(negedge clk); rst_n = 1'b1;
        #1;
        nchk++; if (d1_ready !== 4'b1000) begin
            nerr++; $display("FAIL rmid_after_ready got %b exp 1000", d1_ready); end
        @(posedge clk); #1;
        nchk++; if (m1_valid !== 1'b1 || m1_out !== 8'h93 || m1_chan !== 2'd3 || m1_last !== 1'b1) begin
            nerr++; $display("FAIL rmid_after_out got v=%b d=%h c=%0d l=%b exp 1 93 3 1", m1_valid, m1_out, m1_chan, m1_last); end
        @(negedge clk); d1_valid = '0; d1_last = '0;
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        sel2 = 2'd3; d2_valid = 3'b111; d2_last = 3'b111; m2_ready = 1'b1;
        for (int i = 0; i < 3; i++) d2_data[i*W +: W] = 8'(8'hC0 + i);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            nchk++; if (d2_ready !== 3'b000) begin
                nerr++; $display("FAIL oor_ready cyc%0d got %b exp 000", k, d2_ready); end
            @(posedge clk); #1;
            nchk++; if (m2_valid !== 1'b0) begin
                nerr++; $display("FAIL oor_valid cyc%0d got %b exp 0", k, m2_valid); end
        end
        @(negedge clk); sel2 = 2'd2;
        #1;
        nchk++; if (d2_ready !== 3'b100) begin
            nerr++; $display("FAIL oor_inrange_ready got %b exp 100", d2_ready); end
        @(posedge clk); #1;
        nchk++; if (m2_valid !== 1'b1 || m2_chan !== 2'd2 || m2_out !== 8'hC2) begin
            nerr++; $display("FAIL oor_inrange_out got v=%b c=%0d d=%h exp 1 2 C2", m2_valid, m2_chan, m2_out); end
        @(negedge clk); d2_valid = '0; d2_last = '0;
    endtask

    // Random packets on every channel; each output beat must be the next unsent beat of its
    // channel, and a packet must finish before another channel appears on the output.
    task automatic test_random();
        logic [8:0] src [C][$];
        logic [8:0] exp_q [C][$];
        logic [8:0] e;
        logic [C-1:0] acc;
        logic lock_v;
        logic [1:0] lock_c;
        int remaining, cyc, len;
        remaining = 0; acc = '0; lock_v = 1'b0; lock_c = '0; cyc = 0;
        for (int i = 0; i < C; i++) begin
            for (int p = 0; p < int'($urandom_range(1, 4)); p++) begin
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    e = {b == len - 1, 8'($urandom)};
                    src[i].push_back(e); exp_q[i].push_back(e); remaining++;
                end
            end
        end
        while (remaining > 0 && cyc < 4000) begin
            @(negedge clk); cyc++;
            for (int i = 0; i < C; i++) begin
                if (acc[i]) begin void'(src[i].pop_front()); d1_valid[i] = 1'b0; end
                if (src[i].size() > 0) begin
                    if (!d1_valid[i]) d1_valid[i] = ($urandom_range(0, 3) != 0);
                    d1_data[i*W +: W] = src[i][0][7:0];
                    d1_last[i] = src[i][0][8];
                end else begin
                    d1_valid[i] = 1'b0; d1_last[i] = 1'b0;
                end
            end
            m1_ready = ($urandom_range(0, 3) != 0);
            #1;
            nchk++; if (!$onehot0(d1_ready)) begin
                nerr++; $display("FAIL rand_ready_onehot cyc%0d got %b exp at most one bit", cyc, d1_ready); end
            acc = d1_valid & d1_ready;
            if (m1_valid && m1_ready) begin
                nchk++;
                if (exp_q[m1_chan].size() == 0) begin
                    nerr++; $display("FAIL rand_extra_beat chan%0d got %h exp no beat", m1_chan, {m1_last, m1_out});
                end else begin
                    e = exp_q[m1_chan].pop_front();
                    if ({m1_last, m1_out} !== e) begin
                        nerr++; $display("FAIL rand_beat chan%0d got %h exp %h", m1_chan, {m1_last, m1_out}, e); end
                end
                nchk++; if (lock_v && m1_chan != lock_c) begin
                    nerr++; $display("FAIL rand_interleave got chan %0d exp chan %0d", m1_chan, lock_c); end
                lock_v = !m1_last; lock_c = m1_chan;
                remaining--;
            end
            @(posedge clk);
        end
        nchk++; if (remaining != 0) begin
            nerr++; $display("FAIL rand_timeout got %0d beats outstanding exp 0", remaining); end
        @(negedge clk); d1_valid = '0; d1_last = '0; m1_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rr_order();
        test_sel_packet();
        test_sel_lock();
        test_backpressure();
        test_reset_mid();
        test_out_of_range();
        test_random();
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule
